input_loader: RTL and testbench

INPUT_LOADER -- requirements
Module: input_loader

---
 rtl/input_loader_pkg.sv | 27 ++
 rtl/input_loader_pixel_to_fixed.sv | 21 ++
 rtl/input_loader.sv | 146 ++++++++++++++
 tb/tb_input_loader.sv | 364 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/input_loader_pkg.sv
// input_loader_pkg
//   Shared definitions for the input loader: the input-RAM address map,
//   frame size default, Q5.11 format constants and the loader state type.
//   No ports (package).
package input_loader_pkg;

  // Word addresses of the regions in the shared network BRAM.
  typedef enum logic [9:0] {
    INPUT  = 10'd128,
    HIDDEN = 10'd912,
    OUTPUT = 10'd1008
  } BRAM_ADDRS;

  localparam int NUM_PIXELS_DEFAULT = 784;  // 28x28 frame
  localparam int Q_FRAC_BITS        = 11;   // Q5.11: 1.0 == 1 << 11
  localparam int PIX_W              = 8;
  localparam int ADDR_W             = 10;
  localparam int DATA_W             = 16;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    FIRE,
    WAIT_NN
  } loader_state_t;

endpackage

// File: rtl/input_loader_pixel_to_fixed.sv
// pixel_to_fixed
//   Combinational conversion of an unsigned 8-bit grayscale pixel into
//   Q5.11 fixed point. The pixel is placed so that its MSB lands just
//   below the 1.0 bit, and its top bits are replicated into the vacated
//   LSBs so that 255 maps to 2047 (just under 1.0) rather than 2040.
// Ports:
//   Pix_Data   in  8   unsigned pixel 0..255
//   Fixed_Data out 16  Q5.11 value, 0..2047
module pixel_to_fixed
  import input_loader_pkg::*;
(
  input  logic [PIX_W-1:0]  Pix_Data,
  output logic [DATA_W-1:0] Fixed_Data
);

  localparam int SHL = Q_FRAC_BITS - PIX_W;  // 3

  assign Fixed_Data = (DATA_W'(Pix_Data) << SHL) |
                      DATA_W'(Pix_Data >> (PIX_W - SHL));

endmodule

// File: rtl/input_loader.sv
// input_loader
//   Accepts a pixel stream with valid/ready handshake, writes each pixel
//   (converted to Q5.11) into the network input RAM, starts the network
//   once a full frame is stored, and waits for the network to finish
//   before accepting the next frame.
// Ports:
//   Clk, Reset       clock, synchronous active-high reset
//   Pix_Data/Valid/Sof/Ready  pixel stream handshake (Sof marks index 0)
//   Abort            drop a partially loaded frame (IDLE/LOAD only)
//   NN_Ready         network result valid
//   Wr_En/Addr/Data  input-RAM write port, registered
//   Compute          one-cycle network start pulse
//   Busy             high outside IDLE
//   Frame_Done       one-cycle pulse when the network has finished
module input_loader
  import input_loader_pkg::*;
#(
  parameter int                NUM_PIXELS = NUM_PIXELS_DEFAULT,
  parameter logic [ADDR_W-1:0] BASE_ADDR  = INPUT
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic [PIX_W-1:0]  Pix_Data,
  input  logic              Pix_Valid,
  input  logic              Pix_Sof,
  output logic              Pix_Ready,
  input  logic              Abort,
  input  logic              NN_Ready,
  output logic              Wr_En,
  output logic [ADDR_W-1:0] Wr_Addr,
  output logic [DATA_W-1:0] Wr_Data,
  output logic              Compute,
  output logic              Busy,
  output logic              Frame_Done
);

  localparam logic [ADDR_W-1:0] LAST_INDEX = ADDR_W'(NUM_PIXELS - 1);

  loader_state_t     state_reg, state_next;
  logic [ADDR_W-1:0] index_reg, index_next;
  logic [ADDR_W-1:0] wr_index;
  logic              handshake, accept, last_pixel;
  logic              pix_ready, busy, compute_next, frame_done_next;

  logic              wr_en_reg, compute_reg, frame_done_reg;
  logic [ADDR_W-1:0] wr_addr_reg;
  logic [DATA_W-1:0] wr_data_reg;
  logic [DATA_W-1:0] pix_fixed;

  pixel_to_fixed u_pixel_to_fixed (
    .Pix_Data   (Pix_Data),
    .Fixed_Data (pix_fixed)
  );

  assign handshake = Pix_Valid & pix_ready;

  // State register
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_reg <= IDLE;
      index_reg <= '0;
    end else begin
      state_reg <= state_next;
      index_reg <= index_next;
    end
  end

  // Next-state logic
  always_comb begin
    state_next = state_reg;
    index_next = index_reg;
    accept     = 1'b0;
    // A Sof pixel always restarts the frame at index 0.
    wr_index   = Pix_Sof ? '0 : index_reg;
    last_pixel = (wr_index == LAST_INDEX);
    case (state_reg)
      IDLE, LOAD: begin
        if (Abort) begin
          state_next = IDLE;
          index_next = '0;
        end else if (handshake && (Pix_Sof || state_reg == LOAD)) begin
          accept = 1'b1;
          if (last_pixel) begin
            state_next = FIRE;
            index_next = '0;
          end else begin
            state_next = LOAD;
            index_next = wr_index + ADDR_W'(1);
          end
        end
      end
      FIRE:    state_next = WAIT_NN;
      WAIT_NN: if (frame_done_next) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    pix_ready       = 1'b0;
    busy            = 1'b1;
    compute_next    = 1'b0;
    frame_done_next = 1'b0;
    case (state_reg)
      IDLE: begin
        pix_ready = ~Reset;
        busy      = 1'b0;
      end
      LOAD:    pix_ready = ~Reset;
      FIRE:    compute_next = 1'b1;
      // While Compute is still high the network's Ready may reflect the
      // previous result; ignoring it then also keeps Compute and
      // Frame_Done at least one cycle apart.
      WAIT_NN: frame_done_next = NN_Ready & ~compute_reg;
      default: ;
    endcase
  end

  // Registered outputs
  always_ff @(posedge Clk) begin
    if (Reset) begin
      wr_en_reg      <= 1'b0;
      wr_addr_reg    <= '0;
      wr_data_reg    <= '0;
      compute_reg    <= 1'b0;
      frame_done_reg <= 1'b0;
    end else begin
      wr_en_reg      <= accept;
      if (accept) begin
        wr_addr_reg <= BASE_ADDR + wr_index;
        wr_data_reg <= pix_fixed;
      end
      compute_reg    <= compute_next;
      frame_done_reg <= frame_done_next;
    end
  end

  assign Pix_Ready  = pix_ready;
  assign Busy       = busy;
  assign Wr_En      = wr_en_reg;
  assign Wr_Addr    = wr_addr_reg;
  assign Wr_Data    = wr_data_reg;
  assign Compute    = compute_reg;
  assign Frame_Done = frame_done_reg;

endmodule

// File: tb/tb_input_loader.sv
// tb_input_loader
//   Scoreboard bench for input_loader: expected RAM writes are queued as
//   pixels are driven and compared when Wr_En appears.
module tb_input_loader;
  import input_loader_pkg::*;

  logic       Clk = 1'b0;
  logic       Reset = 1'b1;
  logic [7:0] Pix_Data = '0;
  logic       Pix_Valid = 1'b0;
  logic       Pix_Sof = 1'b0;
  logic       Pix_Ready;
  logic       Abort = 1'b0;
  logic       NN_Ready = 1'b0;
  logic       Wr_En;
  logic [9:0] Wr_Addr;
  logic [15:0] Wr_Data;
  logic       Compute;
  logic       Busy;
  logic       Frame_Done;

  localparam logic [9:0] BASE = INPUT;

  input_loader #(.NUM_PIXELS(784), .BASE_ADDR(INPUT)) dut (
    .Clk        (Clk),
    .Reset      (Reset),
    .Pix_Data   (Pix_Data),
    .Pix_Valid  (Pix_Valid),
    .Pix_Sof    (Pix_Sof),
    .Pix_Ready  (Pix_Ready),
    .Abort      (Abort),
    .NN_Ready   (NN_Ready),
    .Wr_En      (Wr_En),
    .Wr_Addr    (Wr_Addr),
    .Wr_Data    (Wr_Data),
    .Compute    (Compute),
    .Busy       (Busy),
    .Frame_Done (Frame_Done)
  );

  always #5 Clk = ~Clk;

  typedef struct packed {
    logic [9:0]  addr;
    logic [15:0] data;
  } wr_t;

  wr_t sb_q[$];
  int  checks = 0;
  int  failures = 0;
  int  cyc = 0;
  int  compute_count = 0;
  int  frame_done_count = 0;
  int  last_wr_cycle = -1;
  int  last_compute_cycle = -1;
  logic prev_compute = 1'b0;
  logic prev_fd = 1'b0;

  // Q5.11 reference: d<<3 has zero low bits, so OR equals addition.
  function automatic logic [15:0] q511(input logic [7:0] d);
    int v;
    v = int'(d) * 8 + int'(d) / 32;
    return 16'(v);
  endfunction

  // Output monitor, sampled 1 time unit after each rising edge.
  always @(posedge Clk) begin
    wr_t exp_w;
    #1;
    cyc++;
    if (Wr_En) begin
      checks++;
      if (sb_q.size() == 0) begin
        failures++;
        $display("FAIL unexpected_write addr=%0d data=%0d required=no_write", Wr_Addr, Wr_Data);
      end else begin
        exp_w = sb_q.pop_front();
        if (Wr_Addr !== exp_w.addr || Wr_Data !== exp_w.data) begin
          failures++;
          $display("FAIL write addr=%0d data=%0d required addr=%0d data=%0d",
                   Wr_Addr, Wr_Data, exp_w.addr, exp_w.data);
        end
      end
      last_wr_cycle = cyc;
    end
    if (Compute) begin
      compute_count++;
      last_compute_cycle = cyc;
    end
    if (Frame_Done) frame_done_count++;
    if (Compute || Frame_Done) begin
      checks++;
      if ((Compute && (Frame_Done || prev_fd)) || (Frame_Done && prev_compute)) begin
        failures++;
        $display("FAIL compute_done_spacing compute=%0b frame_done=%0b prev_compute=%0b prev_done=%0b required=separated",
                 Compute, Frame_Done, prev_compute, prev_fd);
      end
    end
    prev_compute = Compute;
    prev_fd      = Frame_Done;
  end

  task automatic tick();
    @(negedge Clk);
  endtask

  task automatic send_pix(input logic [7:0] d, input logic sof, input logic exp_wr,
                          input logic [9:0] exp_addr, input logic [15:0] exp_data);
    @(negedge Clk);
    Pix_Valid = 1'b1;
    Pix_Data  = d;
    Pix_Sof   = sof;
    if (exp_wr) sb_q.push_back({exp_addr, exp_data});
  endtask

  task automatic idle_in();
    @(negedge Clk);
    Pix_Valid = 1'b0;
    Pix_Sof   = 1'b0;
    Abort     = 1'b0;
  endtask

  // Sends n accepted pixels for indices start_idx.. with data index%256 or random.
  task automatic send_run(input int n, input int start_idx, input bit sof_first, input bit rnd);
    logic [7:0] d;
    for (int i = 0; i < n; i++) begin
      d = rnd ? 8'($urandom_range(0, 255)) : 8'((start_idx + i) % 256);
      send_pix(d, sof_first && i == 0, 1'b1, BASE + 10'(start_idx + i), q511(d));
    end
  endtask

  task automatic flush_check(input string name);
    for (int k = 0; k < 4; k++) @(negedge Clk);
    checks++;
    if (sb_q.size() != 0) begin
      failures++;
      $display("FAIL %s_pending_writes got=%0d required=0", name, sb_q.size());
      sb_q.delete();
    end
  endtask

  task automatic wait_compute(input int c0, input string name);
    for (int k = 0; k < 12 && compute_count == c0; k++) @(negedge Clk);
    checks++;
    if (compute_count != c0 + 1) begin
      failures++;
      $display("FAIL %s_compute_count got=%0d required=%0d", name, compute_count, c0 + 1);
    end
    checks++;
    if (last_compute_cycle != last_wr_cycle + 1) begin
      failures++;
      $display("FAIL %s_compute_timing got_cycle=%0d required_cycle=%0d", name, last_compute_cycle, last_wr_cycle + 1);
    end
    checks++;
    if (sb_q.size() != 0) begin
      failures++;
      $display("FAIL %s_writes_missing got=%0d required=0", name, sb_q.size());
      sb_q.delete();
    end
  endtask

  // Pulses NN_Ready in WAIT_NN and checks the Frame_Done pulse and return to IDLE.
  task automatic finish_nn(input string name);
    int fd0;
    fd0 = frame_done_count;
    tick(); tick();
    NN_Ready = 1'b1;
    tick();
    NN_Ready = 1'b0;
    checks++;
    if (Frame_Done !== 1'b1 || Busy !== 1'b0 || Pix_Ready !== 1'b1) begin
      failures++;
      $display("FAIL %s_frame_done got done=%0b busy=%0b ready=%0b required done=1 busy=0 ready=1",
               name, Frame_Done, Busy, Pix_Ready);
    end
    tick();
    checks++;
    if (Frame_Done !== 1'b0 || frame_done_count != fd0 + 1) begin
      failures++;
      $display("FAIL %s_done_pulse got done=%0b count=%0d required done=0 count=%0d",
               name, Frame_Done, frame_done_count, fd0 + 1);
    end
  endtask

  task automatic test_reset();
    Reset = 1'b1;
    Pix_Valid = 1'b1;
    tick(); tick();
    checks++;
    if (Pix_Ready !== 1'b0) begin
      failures++;
      $display("FAIL reset_ready_during got=%0b required=0", Pix_Ready);
    end
    checks++;
    if ({Wr_En, Compute, Frame_Done, Busy} !== 4'b0 || Wr_Addr !== 10'd0 || Wr_Data !== 16'd0) begin
      failures++;
      $display("FAIL reset_outputs got en=%0b comp=%0b done=%0b busy=%0b addr=%0d data=%0d required all 0",
               Wr_En, Compute, Frame_Done, Busy, Wr_Addr, Wr_Data);
    end
    Reset = 1'b0;
    Pix_Valid = 1'b0;
    #1;
    checks++;
    if (Pix_Ready !== 1'b1) begin
      failures++;
      $display("FAIL reset_ready_after got=%0b required=1", Pix_Ready);
    end
  endtask

  task automatic test_full_frame();
    int c0;
    c0 = compute_count;
    send_run(784, 0, 1'b1, 1'b0);
    idle_in();
    wait_compute(c0, "full_frame");
    checks++;
    if (Busy !== 1'b1 || Pix_Ready !== 1'b0) begin
      failures++;
      $display("FAIL full_frame_wait_state got busy=%0b ready=%0b required busy=1 ready=0", Busy, Pix_Ready);
    end
  endtask

  task automatic test_wait_nn_hold();
    // Valid with Sof held high, and Abort asserted, must both be ignored.
    Pix_Valid = 1'b1;
    Pix_Sof   = 1'b1;
    Pix_Data  = 8'd77;
    Abort     = 1'b1;
    for (int k = 0; k < 5; k++) begin
      tick();
      checks++;
      if (Pix_Ready !== 1'b0 || Busy !== 1'b1) begin
        failures++;
        $display("FAIL wait_nn_hold cycle=%0d got ready=%0b busy=%0b required ready=0 busy=1", k, Pix_Ready, Busy);
      end
    end
    Abort = 1'b0;
    NN_Ready = 1'b1;
    tick();
    NN_Ready  = 1'b0;
    Pix_Valid = 1'b0;
    Pix_Sof   = 1'b0;
    checks++;
    if (Frame_Done !== 1'b1 || Busy !== 1'b0 || Pix_Ready !== 1'b1) begin
      failures++;
      $display("FAIL wait_nn_release got done=%0b busy=%0b ready=%0b required done=1 busy=0 ready=1",
               Frame_Done, Busy, Pix_Ready);
    end
    flush_check("wait_nn");
  endtask

  task automatic test_resync();
    int c0;
    c0 = compute_count;
    send_run(300, 0, 1'b1, 1'b1);
    send_pix(8'd255, 1'b1, 1'b1, BASE, 16'd2047);
    send_run(782, 1, 1'b0, 1'b1);
    idle_in();
    for (int k = 0; k < 5; k++) tick();
    checks++;
    if (compute_count != c0 || Busy !== 1'b1) begin
      failures++;
      $display("FAIL resync_early_compute got count=%0d busy=%0b required count=%0d busy=1", compute_count, Busy, c0);
    end
    send_run(1, 783, 1'b0, 1'b1);
    idle_in();
    wait_compute(c0, "resync");
    finish_nn("resync");
  endtask

  task automatic test_abort();
    int c0;
    c0 = compute_count;
    send_run(500, 0, 1'b1, 1'b1);
    @(negedge Clk);
    Pix_Valid = 1'b1;
    Pix_Data  = 8'd200;
    Abort     = 1'b1;
    idle_in();
    checks++;
    if (Busy !== 1'b0 || Pix_Ready !== 1'b1) begin
      failures++;
      $display("FAIL abort_state got busy=%0b ready=%0b required busy=0 ready=1", Busy, Pix_Ready);
    end
    // Non-Sof pixels after an abort are dropped.
    for (int k = 0; k < 3; k++) send_pix(8'(k + 1), 1'b0, 1'b0, '0, '0);
    idle_in();
    flush_check("abort");
    checks++;
    if (compute_count != c0 || Busy !== 1'b0) begin
      failures++;
      $display("FAIL abort_no_compute got count=%0d busy=%0b required count=%0d busy=0", compute_count, Busy, c0);
    end
  endtask

  task automatic test_idle_no_sof();
    for (int k = 0; k < 10; k++) send_pix(8'($urandom_range(0, 255)), 1'b0, 1'b0, '0, '0);
    send_pix(8'd128, 1'b1, 1'b1, BASE, 16'd1028);
    send_pix(8'd0, 1'b0, 1'b1, BASE + 10'd1, 16'd0);
    idle_in();
    flush_check("idle_no_sof");
    checks++;
    if (Busy !== 1'b1) begin
      failures++;
      $display("FAIL idle_no_sof_load got busy=%0b required=1", Busy);
    end
    @(negedge Clk);
    Abort = 1'b1;
    idle_in();
    checks++;
    if (Busy !== 1'b0) begin
      failures++;
      $display("FAIL idle_no_sof_abort got busy=%0b required=0", Busy);
    end
  endtask

  task automatic test_reset_wait_nn();
    int c0;
    int fd0;
    c0 = compute_count;
    send_run(784, 0, 1'b1, 1'b1);
    idle_in();
    wait_compute(c0, "reset_wait_nn");
    fd0 = frame_done_count;
    tick();
    Reset    = 1'b1;
    NN_Ready = 1'b1;
    tick(); tick();
    Reset = 1'b0;
    for (int k = 0; k < 4; k++) tick();
    checks++;
    if (frame_done_count != fd0) begin
      failures++;
      $display("FAIL reset_wait_nn_done got count=%0d required=%0d", frame_done_count, fd0);
    end
    checks++;
    if ({Wr_En, Compute, Frame_Done, Busy} !== 4'b0 || Wr_Addr !== 10'd0 || Wr_Data !== 16'd0 ||
        Pix_Ready !== 1'b1) begin
      failures++;
      $display("FAIL reset_wait_nn_outputs got en=%0b comp=%0b done=%0b busy=%0b addr=%0d data=%0d ready=%0b required zeros ready=1",
               Wr_En, Compute, Frame_Done, Busy, Wr_Addr, Wr_Data, Pix_Ready);
    end
    NN_Ready = 1'b0;
  endtask

  initial begin
    test_reset();
    test_full_frame();
    test_wait_nn_hold();
    test_resync();
    test_abort();
    test_idle_no_sof();
    test_reset_wait_nn();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog time limit reached at cycle=%0d", cyc);
    $fatal(1, "watchdog");
  end

endmodule
